// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   ld_state_t : loader FSM states
//   BYTE_W     : width of one stream byte
//   LO_BITS    : instruction bits carried by the even (low) byte
//   HI_BITS    : instruction bits carried by the odd (high) byte
//   hi_ok()    : true when an odd byte has no stray bits above HI_BITS
package loader_pkg;

    localparam int BYTE_W  = 8;
    localparam int LO_BITS = 8;
    localparam int HI_BITS = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_LO = 3'd1,
        GET_HI = 3'd2,
        WRITE  = 3'd3,
        RUN    = 3'd4,
        HALTED = 3'd5
    } ld_state_t;

    function automatic logic hi_ok(input logic [BYTE_W-1:0] b);
        return b[BYTE_W-1:HI_BITS] == '0;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-ROM write port of the loader.
//   in_valid/in_data/in_last : byte source -> loader
//   in_ready                 : loader -> byte source
//   rom_we/rom_addr/rom_wdata: loader -> instruction ROM
// modport slave is the loader side, master is the host/ROM side.
interface prog_loader_if
    import loader_pkg::*;
#(
    parameter int D = 10,
    parameter int W = 9
);
    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              rom_we;
    logic [D-1:0]      rom_addr;
    logic [W-1:0]      rom_wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, rom_we, rom_addr, rom_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, rom_we, rom_addr, rom_wdata
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for the execution cycle count.
//   clk, reset : clock, async active-low reset (clears q)
//   en         : count up this cycle (sticks at all-ones)
//   clr        : synchronous clear, wins over en
//   q          : count value
module sat_counter #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] q
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign q = cnt_q;
endmodule

// File: rtl/prog_loader.sv
// Boot loader: takes 9-bit machine codes as byte pairs (even byte = bits
// [7:0], odd byte = bit 8 in bit 0), writes them into the instruction ROM
// from address 0, then releases the core from reset and counts run cycles
// until core_done.
//   clk, reset  : clock, async active-low reset
//   start       : begin a load (only from IDLE or HALTED)
//   abort       : back to IDLE from anywhere, highest priority
//   bus         : byte stream in + ROM write port out (prog_loader_if.slave)
//   core_reset  : 1 holds the core in reset; 0 only while running
//   core_done   : core finished (looked at only while running)
//   busy        : loading or running
//   err_fmt     : sticky, malformed odd byte or in_last on an even byte
//   err_ovf     : sticky, ROM filled without seeing in_last
//   cycles      : saturating count of run cycles
module prog_loader
    import loader_pkg::*;
#(
    parameter int D  = 10,
    parameter int W  = 9,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    prog_loader_if.slave  bus,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          err_fmt,
    output logic          err_ovf,
    output logic [CW-1:0] cycles
);
    ld_state_t          state_q, state_d;
    logic [D-1:0]       addr_q, addr_d;
    logic [LO_BITS-1:0] lo_q, lo_d;
    logic [W-1:0]       wdata_q, wdata_d;
    logic               last_q, last_d;
    logic               fmt_q, fmt_d;
    logic               ovf_q, ovf_d;
    logic               cnt_clr;
    logic               xfer;

    assign bus.in_ready = (state_q == GET_LO) || (state_q == GET_HI);
    assign xfer         = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        fmt_d   = fmt_q;
        ovf_d   = ovf_q;
        cnt_clr = 1'b0;
        if (abort) begin
            // Errors and datapath registers survive an abort on purpose.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, HALTED: begin
                    if (start) begin
                        state_d = GET_LO;
                        addr_d  = '0;
                        fmt_d   = 1'b0;
                        ovf_d   = 1'b0;
                        cnt_clr = 1'b1;
                    end
                end
                GET_LO: begin
                    if (xfer) begin
                        if (bus.in_last) begin
                            // A program cannot end on half a word.
                            fmt_d   = 1'b1;
                            state_d = HALTED;
                        end else begin
                            lo_d    = bus.in_data[LO_BITS-1:0];
                            state_d = GET_HI;
                        end
                    end
                end
                GET_HI: begin
                    if (xfer) begin
                        wdata_d = W'({bus.in_data[HI_BITS-1:0], lo_q});
                        last_d  = bus.in_last;
                        if (!hi_ok(bus.in_data)) fmt_d = 1'b1;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (last_q) begin
                        state_d = RUN;
                    end else if (addr_q == '1) begin
                        // Full ROM and still no end marker: stop rather than wrap.
                        ovf_d   = 1'b1;
                        state_d = HALTED;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = GET_LO;
                    end
                end
                RUN: begin
                    if (core_done) state_d = HALTED;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lo_q    <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            fmt_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            fmt_q   <= fmt_d;
            ovf_q   <= ovf_d;
        end
    end

    // The cycle in which core_done arrives is still a RUN cycle and is counted.
    sat_counter #(.CW(CW)) u_cycles (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == RUN),
        .clr   (cnt_clr),
        .q     (cycles)
    );

    assign bus.rom_we    = (state_q == WRITE);
    assign bus.rom_addr  = addr_q;
    assign bus.rom_wdata = wdata_q;
    assign core_reset    = (state_q != RUN);
    assign busy          = (state_q != IDLE) && (state_q != HALTED);
    assign err_fmt       = fmt_q;
    assign err_ovf       = ovf_q;
endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        reset, start, abort, core_done;
    logic        core_reset, busy, err_fmt, err_ovf;
    logic [31:0] cycles;
    logic        start2, core_done2;
    logic        core_reset2, busy2, err_fmt2, err_ovf2;
    logic [31:0] cycles2;

    int n_cmp = 0;
    int n_bad = 0;

    prog_loader_if #(.D(10), .W(9)) bus ();
    prog_loader_if #(.D(2),  .W(9)) bus2 ();

    prog_loader #(.D(10), .W(9), .CW(32)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .bus(bus),
        .core_reset(core_reset), .core_done(core_done), .busy(busy),
        .err_fmt(err_fmt), .err_ovf(err_ovf), .cycles(cycles)
    );

    prog_loader #(.D(2), .W(9), .CW(32)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(1'b0), .bus(bus2),
        .core_reset(core_reset2), .core_done(core_done2), .busy(busy2),
        .err_fmt(err_fmt2), .err_ovf(err_ovf2), .cycles(cycles2)
    );

    always #5 clk = ~clk;

    // Reference: the program is a list of words; ROM writes must appear in order at 0,1,2...
    logic [8:0] prog_q[$];
    logic [9:0] wr_addr_q[$];
    logic [8:0] wr_data_q[$];
    int         wr2_n = 0;
    logic [1:0] wr2_last_addr;
    bit         tgl = 1'b0;

    always @(negedge clk) begin
        if (reset && bus.rom_we) begin
            wr_addr_q.push_back(bus.rom_addr);
            wr_data_q.push_back(bus.rom_wdata);
        end
        if (reset && bus2.rom_we) begin
            wr2_n++;
            wr2_last_addr = bus2.rom_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // mode 0: always valid, 1: valid toggles every cycle, 2: random gaps
    task automatic send_byte(input logic [7:0] b, input logic last, input int mode);
        bit done = 1'b0;
        int budget = 0;
        while (!done) begin
            case (mode)
                0:       bus.in_valid = 1'b1;
                1:       begin tgl = ~tgl; bus.in_valid = tgl; end
                default: bus.in_valid = ($urandom_range(99) >= 30);
            endcase
            bus.in_data = b;
            bus.in_last = last;
            done = bus.in_valid && bus.in_ready;
            tick();
            budget++;
            if (!done && budget > 60) begin
                check("byte_timeout", 64'd1, 64'd0);
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Loads prog_q and checks the hand-off to RUN; returns right after the first RUN edge.
    task automatic load_prog(input string tag, input int mode);
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        for (int i = 0; i < prog_q.size(); i++) begin
            send_byte(prog_q[i][7:0], 1'b0, mode);
            send_byte({7'b0, prog_q[i][8]}, (i == prog_q.size() - 1), mode);
        end
        check({tag, "_we_last"}, bus.rom_we, 1'b1);
        check({tag, "_hold_in_write"}, core_reset, 1'b1);
        tick();
        check({tag, "_release"}, core_reset, 1'b0);
        check({tag, "_addr_hold"}, bus.rom_addr, prog_q.size() - 1);
        check({tag, "_n"}, wr_data_q.size(), prog_q.size());
        for (int i = 0; i < prog_q.size() && i < wr_data_q.size(); i++) begin
            check({tag, "_addr"}, wr_addr_q[i], i);
            check({tag, "_data"}, wr_data_q[i], prog_q[i]);
        end
    endtask

    // Core runs k cycles, then raises done; run length is k+1 counted cycles.
    task automatic run_core(input string tag, input int k);
        repeat (k) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check({tag, "_cycles"}, cycles, k + 1);
        check({tag, "_halt_busy"}, busy, 1'b0);
        check({tag, "_halt_hold"}, core_reset, 1'b1);
        repeat (3) tick();
        check({tag, "_cycles_frozen"}, cycles, k + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; core_done = 1'b0;
        start2 = 1'b0; core_done2 = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_last = 1'b0;
        tick(); tick();
        check("rst_ready",  bus.in_ready, 1'b0);
        check("rst_we",     bus.rom_we, 1'b0);
        check("rst_addr",   bus.rom_addr, 0);
        check("rst_wdata",  bus.rom_wdata, 0);
        check("rst_core",   core_reset, 1'b1);
        check("rst_errs",   {err_fmt, err_ovf}, 2'b00);
        check("rst_cycles", cycles, 0);
        check("rst_busy",   busy, 1'b0);
        reset = 1'b1;
        tick();

        // Directed three-word program
        prog_q = '{9'h0A5, 9'h1FF, 9'h000};
        load_prog("dir3", 0);
        check("dir3_busy", busy, 1'b1);
        run_core("dir3", 100);

        // Same image with in_valid toggling
        load_prog("tgl3", 1);
        run_core("tgl3", 3);

        // Random programs, random gaps, random run lengths
        for (int it = 0; it < 6; it++) begin
            int n;
            int k;
            n = $urandom_range(1, 16);
            k = $urandom_range(0, 40);
            prog_q.delete();
            for (int j = 0; j < n; j++) prog_q.push_back(9'($urandom_range(0, 511)));
            load_prog("rnd", 2);
            check("rnd_fmt", err_fmt, 1'b0);
            run_core("rnd", k);
        end

        // start during RUN ignored; abort beats core_done
        prog_q = '{9'h012, 9'h134};
        load_prog("prio", 0);
        pulse_start();
        check("prio_start_ign_busy", busy, 1'b1);
        check("prio_start_ign_core", core_reset, 1'b0);
        abort = 1'b1; core_done = 1'b1;
        tick();
        abort = 1'b0; core_done = 1'b0;
        check("prio_abort_busy", busy, 1'b0);
        check("prio_abort_core", core_reset, 1'b1);

        // Bad odd byte: word still written, err_fmt set
        wr_data_q.delete(); wr_addr_q.delete();
        pulse_start();
        send_byte(8'h34, 1'b0, 0);
        send_byte(8'h03, 1'b1, 0);
        check("fmt_we",    bus.rom_we, 1'b1);
        check("fmt_wdata", bus.rom_wdata, 9'h134);
        check("fmt_flag",  err_fmt, 1'b1);
        tick();
        check("fmt_run", core_reset, 1'b0);
        run_core("fmt", 4);
        check("fmt_sticky", err_fmt, 1'b1);

        // in_last on an even byte: halt, no write
        wr_data_q.delete(); wr_addr_q.delete();
        pulse_start();
        check("fmt2_cleared", err_fmt, 1'b0);
        send_byte(8'h55, 1'b1, 0);
        check("fmt2_flag", err_fmt, 1'b1);
        check("fmt2_busy", busy, 1'b0);
        tick();
        check("fmt2_core",   core_reset, 1'b1);
        check("fmt2_nowr",   wr_data_q.size(), 0);

        // Reset while waiting for the high byte
        pulse_start();
        send_byte(8'h12, 1'b0, 0);
        check("midrst_ready_pre", bus.in_ready, 1'b1);
        reset = 1'b0;
        tick();
        check("midrst_busy",   busy, 1'b0);
        check("midrst_core",   core_reset, 1'b1);
        check("midrst_we",     bus.rom_we, 1'b0);
        check("midrst_cycles", cycles, 0);
        check("midrst_ready",  bus.in_ready, 1'b0);
        reset = 1'b1;
        tick();

        // Overflow on the 4-word ROM: no in_last ever
        begin
            bit saw_low = 1'b0;
            int budget = 0;
            wr2_n = 0;
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            bus2.in_valid = 1'b1; bus2.in_data = 8'h01; bus2.in_last = 1'b0;
            while (busy2 && budget < 40) begin
                if (core_reset2 !== 1'b1) saw_low = 1'b1;
                tick();
                budget++;
            end
            bus2.in_valid = 1'b0;
            check("ovf_done",   busy2, 1'b0);
            check("ovf_flag",   err_ovf2, 1'b1);
            check("ovf_fmt",    err_fmt2, 1'b0);
            check("ovf_core",   core_reset2, 1'b1);
            check("ovf_held",   saw_low, 1'b0);
            tick();
            check("ovf_writes", wr2_n, 4);
            check("ovf_lastad", wr2_last_addr, 2'd3);
            check("ovf_addr",   bus2.rom_addr, 2'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
